res_tx: RTL and testbench

RES_TX -- requirements
Module: res_tx

---
 rtl/res_tx_if.sv | 43 ++++
 rtl/res_tx.sv | 118 +++++++++++
 tb/tb_res_tx.sv | 188 ++++++++++++++++++
 3 files changed

// File: rtl/res_tx_if.sv
// -----------------------------------------------------------------------------
// res_tx_if -- bus bundle for the res_tx parallel-to-serial transmitter.
//
// Signals:
//   data  [N-1:0]  parallel word to send; captured only when a start is accepted
//   start          transfer request, level-sampled on every rising clock edge
//   ready          high while a start will be accepted (transmitter idle)
//   sout           serial data bit, LSB first
//   sval           qualifies sout as a valid bit
//   done           one-cycle pulse marking the end of a transfer
//
// Modports:
//   master  -- drives data/start and observes the transmitter outputs
//   slave   -- the transmitter side (res_tx)
// -----------------------------------------------------------------------------
interface res_tx_if #(
    parameter int N = 4
);
    logic [N-1:0] data;
    logic         start;
    logic         ready;
    logic         sout;
    logic         sval;
    logic         done;

    modport master (
        output data,
        output start,
        input  ready,
        input  sout,
        input  sval,
        input  done
    );

    modport slave (
        input  data,
        input  start,
        output ready,
        output sout,
        output sval,
        output done
    );
endinterface

// File: rtl/res_tx.sv
// -----------------------------------------------------------------------------
// res_tx -- N-bit parallel-to-serial transmitter, LSB first.
//
// A start seen while idle captures the data word into a shift register. The
// word is then presented one bit per cycle on sout with sval high for exactly
// N cycles. A single DONE cycle follows with done high, after which the block
// returns to IDLE and raises ready again. A start arriving while busy is
// dropped, not queued.
//
// Ports:
//   clk   rising-edge clock for all state
//   rst   synchronous, active-high reset (forces IDLE, clears datapath)
//   bus   res_tx_if slave modport (data, start, ready, sout, sval, done)
//
// Every output comes straight from a flop. sout is bit 0 of the shift
// register: the register is zero in IDLE, and after N zero-filled shifts it is
// zero again by the time DONE is reached, so sout is 0 outside SHIFT without
// any gating.
// -----------------------------------------------------------------------------
module res_tx #(
    parameter int N = 4
) (
    input  logic     clk,
    input  logic     rst,
    res_tx_if.slave  bus
);

    // Counter wide enough to hold N itself, so it never wraps mid-transfer.
    localparam int CW = $clog2(N + 1);
    localparam logic [CW-1:0] LAST_IDX = CW'(N - 1);

    typedef enum logic [1:0] {
        IDLE  = 2'b00,
        SHIFT = 2'b01,
        DONE  = 2'b10
    } state_e;

    state_e          state_q;
    logic [N-1:0]    shreg_q;
    logic [CW-1:0]   cnt_q;
    logic            ready_q;
    logic            sval_q;
    logic            done_q;

    // Transfer FSM with its datapath and registered outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            shreg_q <= '0;
            cnt_q   <= '0;
            ready_q <= 1'b1;
            sval_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (bus.start && ready_q) begin
                        state_q <= SHIFT;
                        shreg_q <= bus.data;
                        cnt_q   <= '0;
                        ready_q <= 1'b0;
                        sval_q  <= 1'b1;
                        done_q  <= 1'b0;
                    end else begin
                        state_q <= IDLE;
                        shreg_q <= shreg_q;
                        cnt_q   <= cnt_q;
                        ready_q <= 1'b1;
                        sval_q  <= 1'b0;
                        done_q  <= 1'b0;
                    end
                end

                SHIFT: begin
                    // Zero fill leaves the register clear once all N bits are out.
                    shreg_q <= {1'b0, shreg_q[N-1:1]};
                    cnt_q   <= cnt_q + CW'(1);
                    ready_q <= 1'b0;
                    if (cnt_q == LAST_IDX) begin
                        // Bit N-1 has had its cycle on sout.
                        state_q <= DONE;
                        sval_q  <= 1'b0;
                        done_q  <= 1'b1;
                    end else begin
                        state_q <= SHIFT;
                        sval_q  <= 1'b1;
                        done_q  <= 1'b0;
                    end
                end

                DONE: begin
                    state_q <= IDLE;
                    shreg_q <= '0;
                    cnt_q   <= '0;
                    ready_q <= 1'b1;
                    sval_q  <= 1'b0;
                    done_q  <= 1'b0;
                end

                default: begin
                    // Unused encoding: recover to a clean IDLE.
                    state_q <= IDLE;
                    shreg_q <= '0;
                    cnt_q   <= '0;
                    ready_q <= 1'b1;
                    sval_q  <= 1'b0;
                    done_q  <= 1'b0;
                end
            endcase
        end
    end

    assign bus.ready = ready_q;
    assign bus.sval  = sval_q;
    assign bus.done  = done_q;
    assign bus.sout  = shreg_q[0];

endmodule

// File: tb/tb_res_tx.sv
// -----------------------------------------------------------------------------
// tb_res_tx -- directed bench for res_tx (N=4 and N=8 instances).
//
// Each directed step queues the expected {sout,sval,done,ready} for every cycle
// it is about to drive. The cyc task then applies one cycle of stimulus, and
// one time unit after the rising edge it pops one expectation and compares it
// with the selected instance.
// -----------------------------------------------------------------------------
module tb_res_tx;

    logic clk = 1'b0;
    logic rst;
    logic sel;

    always #5 clk = ~clk;

    res_tx_if #(.N(4)) b4 ();
    res_tx_if #(.N(8)) b8 ();

    res_tx #(.N(4)) dut4 (
        .clk (clk),
        .rst (rst),
        .bus (b4.slave)
    );

    res_tx #(.N(8)) dut8 (
        .clk (clk),
        .rst (rst),
        .bus (b8.slave)
    );

    typedef struct {
        logic [3:0] v;
        string      tag;
    } exp_t;

    exp_t  sbq[$];
    int    nchk  = 0;
    int    npass = 0;
    int    nfail = 0;
    string cur_tag;

    localparam logic [3:0] EXP_IDLE = 4'b0001;
    localparam logic [3:0] EXP_DONE = 4'b0010;

    task automatic push_exp(input logic [3:0] v);
        exp_t e;
        e.v   = v;
        e.tag = cur_tag;
        sbq.push_back(e);
    endtask

    // n data bits LSB first, then the single DONE cycle.
    task automatic push_frame(input logic [7:0] d, input int n);
        for (int i = 0; i < n; i++) begin
            push_exp({d[i], 1'b1, 1'b0, 1'b0});
        end
        push_exp(EXP_DONE);
    endtask

    // One clock of stimulus, then check the selected DUT against the queue.
    task automatic cyc(input logic r, input logic st, input logic [7:0] d);
        exp_t       e;
        logic [3:0] obs;
        rst      = r;
        b4.data  = d[3:0];
        b8.data  = d;
        b4.start = st & ~sel;
        b8.start = st & sel;
        @(posedge clk);
        #1;
        obs = sel ? {b8.sout, b8.sval, b8.done, b8.ready}
                  : {b4.sout, b4.sval, b4.done, b4.ready};
        nchk++;
        assert (sbq.size() > 0) begin
            e = sbq.pop_front();
            assert (obs === e.v) begin
                npass++;
            end else begin
                nfail++;
                $error("FAIL %s: {sout,sval,done,ready} observed=%b expected=%b", e.tag, obs, e.v);
            end
        end else begin
            nfail++;
            $error("FAIL %s: observed=%b expected=<nothing queued>", cur_tag, obs);
        end
    endtask

    initial begin
        rst      = 1'b1;
        sel      = 1'b1;
        b4.start = 1'b0;
        b4.data  = 4'h0;
        b8.start = 1'b0;
        b8.data  = 8'h00;

        // Reset state of both instances.
        cur_tag = "reset8";
        push_exp(EXP_IDLE);
        cyc(1'b1, 1'b0, 8'h00);
        sel = 1'b0;
        cur_tag = "reset4";
        push_exp(EXP_IDLE);
        cyc(1'b1, 1'b0, 8'h00);
        cur_tag = "idle4";
        push_exp(EXP_IDLE);
        cyc(1'b0, 1'b0, 8'h00);

        // Basic frame 1011 -> 1,1,0,1 then done, then ready.
        cur_tag = "frame1011";
        push_frame(8'h0B, 4);
        push_exp(EXP_IDLE);
        cyc(1'b0, 1'b1, 8'h0B);
        repeat (5) cyc(1'b0, 1'b0, 8'h0B);

        // Data changes after capture must not leak into the frame.
        cur_tag = "data_change";
        push_frame(8'h06, 4);
        push_exp(EXP_IDLE);
        cyc(1'b0, 1'b1, 8'h06);
        repeat (5) cyc(1'b0, 1'b0, 8'h0F);

        // Starts while busy (2nd SHIFT cycle, DONE cycle) are dropped.
        cur_tag = "busy_start";
        push_frame(8'h0C, 4);
        push_exp(EXP_IDLE);
        push_exp(EXP_IDLE);
        cyc(1'b0, 1'b1, 8'h0C);
        cyc(1'b0, 1'b0, 8'h0C);
        cyc(1'b0, 1'b1, 8'h0C);
        cyc(1'b0, 1'b0, 8'h0C);
        cyc(1'b0, 1'b0, 8'h0C);
        cyc(1'b0, 1'b1, 8'h0C);
        cyc(1'b0, 1'b0, 8'h0C);

        // start held 20 cycles: frames 1,0,0,1 every 6 cycles.
        cur_tag = "held_start";
        for (int f = 0; f < 4; f++) begin
            push_frame(8'h09, 4);
            push_exp(EXP_IDLE);
        end
        repeat (20) cyc(1'b0, 1'b1, 8'h09);
        repeat (4) cyc(1'b0, 1'b0, 8'h09);

        // rst in the 3rd SHIFT cycle, together with start: abort, no done.
        cur_tag = "abort";
        push_exp(4'b1100);
        push_exp(4'b0100);
        push_exp(4'b1100);
        push_exp(EXP_IDLE);
        push_exp(EXP_IDLE);
        push_exp(EXP_IDLE);
        cyc(1'b0, 1'b1, 8'h05);
        cyc(1'b0, 1'b0, 8'h05);
        cyc(1'b0, 1'b0, 8'h05);
        cyc(1'b1, 1'b1, 8'h05);
        cyc(1'b0, 1'b0, 8'h05);
        cyc(1'b0, 1'b0, 8'h05);

        // rst beats start while idle.
        cur_tag = "rst_prio";
        push_exp(EXP_IDLE);
        push_exp(EXP_IDLE);
        cyc(1'b1, 1'b1, 8'h0F);
        cyc(1'b0, 1'b0, 8'h0F);

        // Wide instance: A5 -> 1,0,1,0,0,1,0,1, done in 9th cycle.
        sel = 1'b1;
        cur_tag = "frameA5_n8";
        push_frame(8'hA5, 8);
        push_exp(EXP_IDLE);
        cyc(1'b0, 1'b1, 8'hA5);
        repeat (9) cyc(1'b0, 1'b0, 8'h00);

        // Every queued expectation must have been consumed.
        nchk++;
        assert (sbq.size() == 0) begin
            npass++;
        end else begin
            nfail++;
            $error("FAIL drain: leftover expectations=%0d expected=0", sbq.size());
        end

        $display("%0d/%0d checks passed", npass, nchk);
        $finish;
    end

endmodule
